ps2_key_tracker: RTL and testbench



---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_rx.sv | 101 ++++++++++
 rtl/ps2_key_tracker.sv | 110 +++++++++++
 tb/tb_ps2_key_tracker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key tracker.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    BREAK = 2'd2
  } key_state_e;

  localparam logic [7:0]  BREAK_CODE = 8'hF0;
  localparam logic [7:0]  EXT_CODE   = 8'hE0;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned BIT_CNT_W  = 4;

  // Frame is {stop, parity, data[7:0], start}; start=0, stop=1, odd parity over data+parity.
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return (f[0] == 1'b0) && (f[FRAME_BITS-1] == 1'b1) && (^f[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchroniser, falling-edge detect, shift register, frame checks, timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_stb,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   stb_q, stb_d;
  logic                   err_q, err_d;
  logic [7:0]             byte_q, byte_d;
  logic                   clk_s, data_s, fall;

  // Next-state: sample on synced falling edge, check on the 11th bit, abandon stale partial frames.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_s       = clk_sync_q[SYNC_STAGES-1];
    data_s      = data_sync_q[SYNC_STAGES-1];
    fall        = clk_prev_q & ~clk_s;
    clk_prev_d  = clk_s;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    byte_d      = byte_q;
    stb_d       = 1'b0;
    err_d       = 1'b0;

    if (fall) begin
      // A fall always wins over a coincident timeout.
      shift_d  = {data_s, shift_q[FRAME_BITS-1:1]};
      to_cnt_d = '0;
      if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
        bit_cnt_d = '0;
        if (frame_ok(shift_d)) begin
          stb_d  = 1'b1;
          byte_d = shift_d[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      end
    end else if (bit_cnt_q != '0) begin
      if (to_cnt_q == TO_W'(TIMEOUT)) begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      stb_q       <= 1'b0;
      err_q       <= 1'b0;
      byte_q      <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      stb_q       <= stb_d;
      err_q       <= err_d;
      byte_q      <= byte_d;
    end
  end

  assign byte_stb  = stb_q;
  assign rx_byte   = byte_q;
  assign frame_err = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks the held PS/2 key (make/break) and a BCD press count for the hex digit decoders.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key_hi,
  output logic [3:0] key_lo,
  output logic [3:0] cnt_hi,
  output logic [3:0] cnt_lo,
  output logic       key_valid,
  output logic       frame_err
);

  logic       rx_stb;
  logic [7:0] rx_byte;

  ps2_rx #(
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byte_stb (rx_stb),
    .rx_byte  (rx_byte),
    .frame_err(frame_err)
  );

  key_state_e state_q, state_d;
  logic [7:0] key_q, key_d;
  logic [3:0] cnt_hi_q, cnt_hi_d;
  logic [3:0] cnt_lo_q, cnt_lo_d;
  logic       valid_q, valid_d;
  logic       inc;

  // Key FSM and BCD press counter, advanced only by accepted non-prefix bytes.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    cnt_hi_d = cnt_hi_q;
    cnt_lo_d = cnt_lo_q;
    inc      = 1'b0;

    if (rx_stb && (rx_byte != EXT_CODE)) begin
      unique case (state_q)
        IDLE: begin
          if (rx_byte == BREAK_CODE) begin
            state_d = BREAK;
          end else begin
            state_d = HELD;
            key_d   = rx_byte;
            inc     = 1'b1;
          end
        end
        HELD: begin
          if (rx_byte == BREAK_CODE) begin
            state_d = BREAK;
          end else if (rx_byte != key_q) begin
            key_d = rx_byte;
            inc   = 1'b1;
          end
        end
        BREAK:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (inc) begin
      if (cnt_lo_q == 4'd9) begin
        cnt_lo_d = 4'd0;
        cnt_hi_d = (cnt_hi_q == 4'd9) ? 4'd0 : cnt_hi_q + 4'd1;
      end else begin
        cnt_lo_d = cnt_lo_q + 4'd1;
      end
    end

    valid_d = (state_d == HELD);
  end

  // Registered FSM state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      key_q    <= '0;
      cnt_hi_q <= '0;
      cnt_lo_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      cnt_hi_q <= cnt_hi_d;
      cnt_lo_q <= cnt_lo_d;
      valid_q  <= valid_d;
    end
  end

  assign key_hi    = key_q[7:4];
  assign key_lo    = key_q[3:0];
  assign cnt_hi    = cnt_hi_q;
  assign cnt_lo    = cnt_lo_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: driver pushes expected responses, monitor checks them.
module tb_ps2_key_tracker;

  localparam int unsigned TO = 200;
  localparam int unsigned SS = 3;
  localparam int unsigned H  = 4;

  localparam int M_IDLE  = 0;
  localparam int M_HELD  = 1;
  localparam int M_BREAK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key_hi, key_lo, cnt_hi, cnt_lo;
  logic       key_valid, frame_err;

  ps2_key_tracker #(.TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_hi   (key_hi),
    .key_lo   (key_lo),
    .cnt_hi   (cnt_hi),
    .cnt_lo   (cnt_lo),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       err;
    logic [7:0] key;
    logic [3:0] chi;
    logic [3:0] clo;
    logic       valid;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int exp_errs = 0;

  int         m_state = M_IDLE;
  logic [7:0] m_key   = 8'h00;
  int         m_cnt   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_state = M_IDLE;
    m_key   = 8'h00;
    m_cnt   = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) return;
    case (m_state)
      M_IDLE: begin
        if (b == 8'hF0) m_state = M_BREAK;
        else begin
          m_state = M_HELD;
          m_key   = b;
          m_cnt   = (m_cnt + 1) % 100;
        end
      end
      M_HELD: begin
        if (b == 8'hF0) m_state = M_BREAK;
        else if (b != m_key) begin
          m_key = b;
          m_cnt = (m_cnt + 1) % 100;
        end
      end
      default: m_state = M_IDLE;
    endcase
  endfunction

  function automatic exp_t snap(input int due, input logic err);
    exp_t e;
    e.due   = due;
    e.err   = err;
    e.key   = m_key;
    e.chi   = 4'(m_cnt / 10);
    e.clo   = 4'(m_cnt % 10);
    e.valid = (m_state == M_HELD);
    return e;
  endfunction

  // Called at the stop-bit fall: old outputs + frame_err next, new outputs one cycle later.
  function automatic void frame_done(input int n, input logic [7:0] b, input logic bad);
    sbq.push_back(snap(n + int'(SS) + 1, bad));
    if (!bad) model_byte(b);
    sbq.push_back(snap(n + int'(SS) + 2, 1'b0));
    if (bad) exp_errs++;
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nb, input logic bad);
    for (int i = 0; i < nb; i++) begin
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) frame_done(cyc, bits[8:1], bad);
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip, b, 1'b0};
    send_bits(bits, 11, flip);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic expect_out(input string tag, input logic [7:0] key, input logic [3:0] chi,
                            input logic [3:0] clo, input logic valid);
    chk({tag, ".key_hi"}, 8'(key_hi), 8'(key[7:4]));
    chk({tag, ".key_lo"}, 8'(key_lo), 8'(key[3:0]));
    chk({tag, ".cnt_hi"}, 8'(cnt_hi), 8'(chi));
    chk({tag, ".cnt_lo"}, 8'(cnt_lo), 8'(clo));
    chk({tag, ".key_valid"}, 8'(key_valid), 8'(valid));
  endtask

  // Monitor: compares the DUT against scoreboard entries when their cycle comes due.
  exp_t me;
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_seen++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      me = sbq.pop_front();
      chk("sb.frame_err", 8'(frame_err), 8'(me.err));
      chk("sb.key_hi", 8'(key_hi), 8'(me.key[7:4]));
      chk("sb.key_lo", 8'(key_lo), 8'(me.key[3:0]));
      chk("sb.cnt_hi", 8'(cnt_hi), 8'(me.chi));
      chk("sb.cnt_lo", 8'(cnt_lo), 8'(me.clo));
      chk("sb.key_valid", 8'(key_valid), 8'(me.valid));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    expect_out("reset", 8'h00, 4'd0, 4'd0, 1'b0);
    chk("reset.frame_err", 8'(frame_err), 8'h00);

    // Bad parity after reset: one-cycle frame_err, nothing else moves.
    send_byte(8'h1C, 1'b1);
    expect_out("parity", 8'h00, 4'd0, 4'd0, 1'b0);

    // First make code.
    send_byte(8'h1C, 1'b0);
    expect_out("make1c", 8'h1C, 4'd0, 4'd1, 1'b1);

    // Typematic repeats, extended prefix, then break.
    repeat (3) send_byte(8'h1C, 1'b0);
    send_byte(8'hE0, 1'b0);
    expect_out("repeat", 8'h1C, 4'd0, 4'd1, 1'b1);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    expect_out("break1c", 8'h1C, 4'd0, 4'd1, 1'b0);

    // Reset mid-frame drops the partial 0x32 frame.
    send_byte(8'h1C, 1'b0);
    expect_out("make1c_b", 8'h1C, 4'd0, 4'd2, 1'b1);
    send_bits({1'b1, ~^8'h32, 8'h32, 1'b0}, 5, 1'b0);
    do_reset();
    expect_out("midrst", 8'h00, 4'd0, 4'd0, 1'b0);
    chk("midrst.frame_err", 8'(frame_err), 8'h00);
    repeat (4) @(negedge clk);
    send_byte(8'h24, 1'b0);
    expect_out("make24", 8'h24, 4'd0, 4'd1, 1'b1);

    // Partial frame abandoned by timeout, then a clean frame.
    do_reset();
    send_bits({1'b1, ~^8'h77, 8'h77, 1'b0}, 5, 1'b0);
    repeat (TO + 2) @(negedge clk);
    send_byte(8'h45, 1'b0);
    expect_out("timeout", 8'h45, 4'd0, 4'd1, 1'b1);

    // 100 make/break pairs: count wraps 99 -> 00.
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      send_byte(8'h32, 1'b0);
      if (i == 98) expect_out("press98", 8'h32, 4'd9, 4'd8, 1'b1);
      if (i == 99) expect_out("press99", 8'h32, 4'd9, 4'd9, 1'b1);
      if (i == 100) expect_out("press100", 8'h32, 4'd0, 4'd0, 1'b1);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h32, 1'b0);
    end
    expect_out("pairs_end", 8'h32, 4'd0, 4'd0, 1'b0);

    repeat (10) @(negedge clk);
    chk("sb.drained", 8'(sbq.size()), 8'h00);
    chk("frame_err.count", 8'(err_seen), 8'(exp_errs));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
